// File: rtl/num_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : num_entry_ctrl
// Brief    : Operator number-entry controller. Edits a BCD digit buffer from
//            debounced button pulses, converts it to binary, and hands it to
//            the factorizer core over a REQ/ACK handshake, then waits for DONE
//            and holds the result-display state until the operator returns.
// Revision : 1.0 - initial release
// ============================================================================
module num_entry_ctrl #(
    parameter int DIGITS = 4,
    parameter int NW     = 14,
    parameter int CW     = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [6:0]          BTN,
    output logic [4*DIGITS-1:0] DIG,
    output logic [CW-1:0]       CUR,
    output logic [NW-1:0]       NUM,
    output logic                REQ,
    input  logic                ACK,
    input  logic                DONE,
    output logic [2:0]          STATE,
    output logic                ERR
);

    typedef enum logic [2:0] {
        S_EDIT = 3'd0,
        S_CONV = 3'd1,
        S_REQ  = 3'd2,
        S_BUSY = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [NW-1:0] c_TEN      = NW'(10);
    localparam logic [NW-1:0] c_TWO      = NW'(2);
    localparam logic [CW-1:0] c_LAST_CUR = CW'(DIGITS - 1);

    state_t              r_state, w_state_nxt;
    logic [4*DIGITS-1:0] r_dig,   w_dig_nxt;
    logic [CW-1:0]       r_cur,   w_cur_nxt;
    logic [NW-1:0]       r_num,   w_num_nxt;
    logic                r_req,   w_req_nxt;
    logic                r_err,   w_err_nxt;
    logic [NW-1:0]       r_acc,   w_acc_nxt;
    logic [CW-1:0]       r_idx,   w_idx_nxt;

    logic [3:0]          w_idx_dig;
    logic [3:0]          w_cur_dig;
    logic [NW-1:0]       w_acc_new;

    // One-hot priority decode: CLR > QUE > SEL > INC > DEC > RDY.
    logic w_clr, w_que, w_sel, w_inc, w_dec, w_rdy;
    assign w_clr = BTN[3];
    assign w_que = BTN[4] & ~BTN[3];
    assign w_sel = BTN[2] & ~BTN[4] & ~BTN[3];
    assign w_inc = BTN[0] & ~BTN[2] & ~BTN[4] & ~BTN[3];
    assign w_dec = BTN[1] & ~BTN[0] & ~BTN[2] & ~BTN[4] & ~BTN[3];
    assign w_rdy = BTN[5] & ~BTN[1] & ~BTN[0] & ~BTN[2] & ~BTN[4] & ~BTN[3];

    // State and datapath registers; every output comes straight from here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_EDIT;
            r_dig   <= '0;
            r_cur   <= '0;
            r_num   <= '0;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
            r_acc   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dig   <= w_dig_nxt;
            r_cur   <= w_cur_nxt;
            r_num   <= w_num_nxt;
            r_req   <= w_req_nxt;
            r_err   <= w_err_nxt;
            r_acc   <= w_acc_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state, editing and conversion logic.
    always_comb begin
        w_state_nxt = r_state;
        w_dig_nxt   = r_dig;
        w_cur_nxt   = r_cur;
        w_num_nxt   = r_num;
        w_req_nxt   = r_req;
        w_err_nxt   = r_err;
        w_acc_nxt   = r_acc;
        w_idx_nxt   = r_idx;
        w_idx_dig   = 4'd0;
        w_cur_dig   = 4'd0;

        // Digit currently being converted and digit under the cursor.
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == CW'(k)) w_idx_dig = r_dig[4*k +: 4];
            if (r_cur == CW'(k)) w_cur_dig = r_dig[4*k +: 4];
        end
        w_acc_new = (r_acc * c_TEN) + NW'(w_idx_dig);

        case (r_state)
            S_EDIT: begin
                if (w_clr) begin
                    w_dig_nxt = '0;
                    w_cur_nxt = '0;
                    w_err_nxt = 1'b0;
                end else if (w_que) begin
                    w_err_nxt   = 1'b0;
                    w_acc_nxt   = '0;
                    w_idx_nxt   = c_LAST_CUR;
                    w_state_nxt = S_CONV;
                end else if (w_sel) begin
                    w_err_nxt = 1'b0;
                    w_cur_nxt = (r_cur == c_LAST_CUR) ? '0 : r_cur + 1'b1;
                end else if (w_inc || w_dec) begin
                    w_err_nxt = 1'b0;
                    for (int k = 0; k < DIGITS; k++) begin
                        if (r_cur == CW'(k)) begin
                            if (w_inc)
                                w_dig_nxt[4*k +: 4] = (w_cur_dig == 4'd9) ? 4'd0 : w_cur_dig + 4'd1;
                            else
                                w_dig_nxt[4*k +: 4] = (w_cur_dig == 4'd0) ? 4'd9 : w_cur_dig - 4'd1;
                        end
                    end
                end
            end

            // Horner evaluation, most significant digit first, one per cycle.
            S_CONV: begin
                w_acc_nxt = w_acc_new;
                if (r_idx == '0) begin
                    if (w_acc_new < c_TWO) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_EDIT;
                    end else begin
                        w_num_nxt   = w_acc_new;
                        w_req_nxt   = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end else begin
                    w_idx_nxt = r_idx - 1'b1;
                end
            end

            // ACK beats a simultaneous CLR: the core already took the job.
            S_REQ: begin
                if (ACK) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_BUSY;
                end else if (w_clr) begin
                    w_req_nxt   = 1'b0;
                    w_dig_nxt   = '0;
                    w_cur_nxt   = '0;
                    w_state_nxt = S_EDIT;
                end
            end

            S_BUSY: begin
                if (DONE) w_state_nxt = S_SHOW;
            end

            S_SHOW: begin
                if (w_clr) begin
                    w_dig_nxt   = '0;
                    w_cur_nxt   = '0;
                    w_state_nxt = S_EDIT;
                end else if (w_rdy) begin
                    w_state_nxt = S_EDIT;
                end
            end

            default: begin
                w_state_nxt = S_EDIT;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    assign DIG   = r_dig;
    assign CUR   = r_cur;
    assign NUM   = r_num;
    assign REQ   = r_req;
    assign ERR   = r_err;
    assign STATE = r_state;

endmodule
`default_nettype wire

// File: tb/tb_num_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_num_entry_ctrl
// Brief    : Directed self-checking bench for num_entry_ctrl (DIGITS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_num_entry_ctrl;

    localparam int DIGITS = 4;
    localparam int NW     = 14;
    localparam int CW     = 2;

    localparam logic [6:0] c_NONE = 7'h00;
    localparam logic [6:0] c_INC  = 7'h01;
    localparam logic [6:0] c_DEC  = 7'h02;
    localparam logic [6:0] c_SEL  = 7'h04;
    localparam logic [6:0] c_CLR  = 7'h08;
    localparam logic [6:0] c_QUE  = 7'h10;
    localparam logic [6:0] c_RDY  = 7'h20;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [6:0]          BTN = '0;
    logic                ACK = 1'b0;
    logic                DONE = 1'b0;
    logic [4*DIGITS-1:0] DIG;
    logic [CW-1:0]       CUR;
    logic [NW-1:0]       NUM;
    logic                REQ;
    logic [2:0]          STATE;
    logic                ERR;

    int n_chk = 0;
    int n_err = 0;

    num_entry_ctrl #(.DIGITS(DIGITS), .NW(NW), .CW(CW)) dut (
        .CLK(CLK), .RST(RST), .BTN(BTN), .DIG(DIG), .CUR(CUR), .NUM(NUM),
        .REQ(REQ), .ACK(ACK), .DONE(DONE), .STATE(STATE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs for one cycle, let one edge sample them, settle after it.
    task automatic step(input logic [6:0] b, input logic a, input logic d);
        BTN  = b;
        ACK  = a;
        DONE = d;
        @(posedge CLK);
        #1;
        BTN  = '0;
        ACK  = 1'b0;
        DONE = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".DIG"},   32'(DIG),   32'h0);
        chk({tag, ".CUR"},   32'(CUR),   32'h0);
        chk({tag, ".NUM"},   32'(NUM),   32'h0);
        chk({tag, ".REQ"},   32'(REQ),   32'h0);
        chk({tag, ".STATE"}, 32'(STATE), 32'h0);
        chk({tag, ".ERR"},   32'(ERR),   32'h0);
    endtask

    // QUE then DIGITS conversion cycles; caller checks the outcome.
    task automatic convert();
        step(c_QUE, 1'b0, 1'b0);
        for (int i = 0; i < DIGITS; i++) step(c_NONE, 1'b0, 1'b0);
    endtask

    initial begin
        RST = 1'b1;
        step(c_NONE, 1'b0, 1'b0);
        step(c_NONE, 1'b0, 1'b0);
        RST = 1'b0;
        chk_reset("reset");

        // Basic editing with wraps on DEC.
        repeat (3) step(c_INC, 1'b0, 1'b0);
        step(c_SEL, 1'b0, 1'b0);
        repeat (2) step(c_DEC, 1'b0, 1'b0);
        step(c_SEL, 1'b0, 1'b0);
        step(c_INC, 1'b0, 1'b0);
        chk("edit.DIG", 32'(DIG), 32'h0183);
        chk("edit.CUR", 32'(CUR), 32'd2);
        repeat (10) step(c_INC, 1'b0, 1'b0);
        chk("inc_wrap.DIG", 32'(DIG), 32'h0183);

        // Enter 1234 and run the full handshake.
        step(c_CLR, 1'b0, 1'b0);
        chk("clr.DIG", 32'(DIG), 32'h0);
        repeat (4) step(c_INC, 1'b0, 1'b0);
        step(c_SEL, 1'b0, 1'b0);
        repeat (3) step(c_INC, 1'b0, 1'b0);
        step(c_SEL, 1'b0, 1'b0);
        repeat (2) step(c_INC, 1'b0, 1'b0);
        step(c_SEL, 1'b0, 1'b0);
        step(c_INC, 1'b0, 1'b0);
        chk("e1234.DIG", 32'(DIG), 32'h1234);
        chk("e1234.CUR", 32'(CUR), 32'd3);
        step(c_QUE, 1'b0, 1'b0);
        chk("conv1.STATE", 32'(STATE), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            step(c_NONE, 1'b0, 1'b0);
            chk("convN.STATE", 32'(STATE), 32'd1);
            chk("convN.REQ", 32'(REQ), 32'd0);
        end
        step(c_NONE, 1'b0, 1'b0);
        chk("req.STATE", 32'(STATE), 32'd2);
        chk("req.REQ", 32'(REQ), 32'd1);
        chk("req.NUM", 32'(NUM), 32'd1234);
        repeat (3) begin
            step(c_NONE, 1'b0, 1'b0);
            chk("hold.REQ", 32'(REQ), 32'd1);
        end
        step(c_NONE, 1'b1, 1'b0);
        chk("ack.REQ", 32'(REQ), 32'd0);
        chk("ack.STATE", 32'(STATE), 32'd3);
        step(c_NONE, 1'b0, 1'b1);
        chk("done.STATE", 32'(STATE), 32'd4);
        step(c_RDY, 1'b0, 1'b0);
        chk("rdy.STATE", 32'(STATE), 32'd0);
        chk("rdy.DIG", 32'(DIG), 32'h1234);
        chk("rdy.NUM", 32'(NUM), 32'd1234);

        // Value below 2 is rejected.
        step(c_CLR, 1'b0, 1'b0);
        step(c_INC, 1'b0, 1'b0);
        convert();
        chk("small.STATE", 32'(STATE), 32'd0);
        chk("small.ERR", 32'(ERR), 32'd1);
        chk("small.REQ", 32'(REQ), 32'd0);
        step(c_INC, 1'b0, 1'b0);
        chk("errclr.ERR", 32'(ERR), 32'd0);
        chk("errclr.DIG", 32'(DIG), 32'h0002);

        // Withdraw in REQ with CLR.
        convert();
        chk("wd.pre.REQ", 32'(REQ), 32'd1);
        chk("wd.pre.NUM", 32'(NUM), 32'd2);
        step(c_CLR, 1'b0, 1'b0);
        chk("wd.REQ", 32'(REQ), 32'd0);
        chk("wd.DIG", 32'(DIG), 32'h0);
        chk("wd.CUR", 32'(CUR), 32'd0);
        chk("wd.STATE", 32'(STATE), 32'd0);

        // ACK and CLR together: ACK wins.
        repeat (3) step(c_INC, 1'b0, 1'b0);
        convert();
        chk("ackclr.pre.NUM", 32'(NUM), 32'd3);
        step(c_CLR, 1'b1, 1'b0);
        chk("ackclr.STATE", 32'(STATE), 32'd3);
        chk("ackclr.REQ", 32'(REQ), 32'd0);
        chk("ackclr.DIG", 32'(DIG), 32'h0003);

        // BUSY ignores every button.
        step(7'h7f, 1'b0, 1'b0);
        chk("busy.STATE", 32'(STATE), 32'd3);
        chk("busy.DIG", 32'(DIG), 32'h0003);
        chk("busy.CUR", 32'(CUR), 32'd0);
        step(c_NONE, 1'b0, 1'b1);
        chk("busy.done", 32'(STATE), 32'd4);
        step(c_INC, 1'b0, 1'b0);
        chk("show.inc.DIG", 32'(DIG), 32'h0003);
        chk("show.inc.STATE", 32'(STATE), 32'd4);
        step(c_CLR, 1'b0, 1'b0);
        chk("show.clr.STATE", 32'(STATE), 32'd0);
        chk("show.clr.DIG", 32'(DIG), 32'h0);

        // Simultaneous pulses: highest priority acts alone.
        step(c_INC, 1'b0, 1'b0);
        step(c_INC, 1'b0, 1'b0);
        step(7'b0000101, 1'b0, 1'b0);
        chk("prio.sel.CUR", 32'(CUR), 32'd1);
        chk("prio.sel.DIG", 32'(DIG), 32'h0002);
        step(7'b0010101, 1'b0, 1'b0);
        chk("prio.que.STATE", 32'(STATE), 32'd1);
        chk("prio.que.CUR", 32'(CUR), 32'd1);
        chk("prio.que.DIG", 32'(DIG), 32'h0002);

        // RST mid-CONV.
        step(c_NONE, 1'b0, 1'b0);
        RST = 1'b1;
        step(c_NONE, 1'b0, 1'b0);
        RST = 1'b0;
        chk_reset("rst_conv");

        // RST mid-REQ.
        repeat (5) step(c_INC, 1'b0, 1'b0);
        convert();
        chk("rst_req.pre.REQ", 32'(REQ), 32'd1);
        chk("rst_req.pre.NUM", 32'(NUM), 32'd5);
        RST = 1'b1;
        step(c_NONE, 1'b1, 1'b0);
        RST = 1'b0;
        chk_reset("rst_req");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
